// File: rtl/pipelined_adder_tree_acc.sv
// Pipelined NUM_IN-to-1 signed adder tree feeding a multi-beat group accumulator.
// Define ACC_SAT_EN to saturate the accumulator and report clamps on out_ovf.
module pipelined_adder_tree_acc #(
   parameter int NUM_IN    = 8,
   parameter int IN_WIDTH  = 16,
   parameter int ACC_WIDTH = 24
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_IN*IN_WIDTH-1:0]   in_vec,
   input  logic                         in_first,
   input  logic                         in_last,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [ACC_WIDTH-1:0]         out_data,
   output logic                         out_ovf,
   output logic                         out_valid,
   input  logic                         out_ready
);
   localparam int LEVELS = $clog2(NUM_IN);
   localparam int TW     = IN_WIDTH + LEVELS;

   // Handshake: a beat moves on in_valid && in_ready, a result on out_valid && out_ready.
   // A pending unaccepted result freezes every stage, so in_ready is simply !stall.
   logic stall;
   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      localparam int NS = NUM_IN >> (k + 1);
      localparam int WS = IN_WIDTH + k;

      logic signed [WS-1:0] src [2*NS];
      logic                 src_vld;
      logic                 src_first;
      logic                 src_last;
      logic signed [WS:0]   sum_q [NS];
      logic                 vld_q;
      logic                 first_q;
      logic                 last_q;

      if (k == 0) begin : g_src
         always_comb begin
            for (int i = 0; i < 2*NS; i++) src[i] = in_vec[i*IN_WIDTH +: IN_WIDTH];
            src_vld   = in_valid;
            src_first = in_first;
            src_last  = in_last;
         end
      end else begin : g_src
         always_comb begin
            for (int i = 0; i < 2*NS; i++) src[i] = g_lvl[k-1].sum_q[i];
            src_vld   = g_lvl[k-1].vld_q;
            src_first = g_lvl[k-1].first_q;
            src_last  = g_lvl[k-1].last_q;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) vld_q <= 1'b0;
         else if (!stall) vld_q <= src_vld;
      end

      // Each level grows by one bit so pair sums never overflow.
      always_ff @(posedge clk) begin
         if (!stall) begin
            first_q <= src_first;
            last_q  <= src_last;
            for (int i = 0; i < NS; i++)
               sum_q[i] <= (WS+1)'(src[2*i]) + (WS+1)'(src[2*i+1]);
         end
      end
   end

   logic signed [TW-1:0] tree_sum;
   logic                 tree_vld;
   logic                 tree_first;
   logic                 tree_last;
   assign tree_sum   = g_lvl[LEVELS-1].sum_q[0];
   assign tree_vld   = g_lvl[LEVELS-1].vld_q;
   assign tree_first = g_lvl[LEVELS-1].first_q;
   assign tree_last  = g_lvl[LEVELS-1].last_q;

   logic signed [ACC_WIDTH-1:0] acc_q;
   logic signed [ACC_WIDTH-1:0] acc_base;
   logic signed [ACC_WIDTH-1:0] acc_nxt;
   assign acc_base = tree_first ? '0 : acc_q;

`ifdef ACC_SAT_EN
   localparam int SW = ((ACC_WIDTH > TW) ? ACC_WIDTH : TW) + 1;
   localparam logic signed [SW-1:0] MAX_V = {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] MIN_V = {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

   logic signed [SW-1:0] sum_full;
   logic                 clamp;
   logic                 ovf_q;
   logic                 ovf_nxt;
   logic                 out_ovf_q;

   always_comb begin
      sum_full = SW'(acc_base) + SW'(tree_sum);
      clamp    = 1'b0;
      acc_nxt  = sum_full[ACC_WIDTH-1:0];
      if (sum_full > MAX_V) begin
         acc_nxt = MAX_V[ACC_WIDTH-1:0];
         clamp   = 1'b1;
      end else if (sum_full < MIN_V) begin
         acc_nxt = MIN_V[ACC_WIDTH-1:0];
         clamp   = 1'b1;
      end
      ovf_nxt = (tree_first ? 1'b0 : ovf_q) | clamp;
   end

   // Sticky clamp flag for the current group, snapshotted alongside out_data.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q     <= 1'b0;
         out_ovf_q <= 1'b0;
      end else if (!stall && tree_vld) begin
         ovf_q <= ovf_nxt;
         if (tree_last) out_ovf_q <= ovf_nxt;
      end
   end
   assign out_ovf = out_ovf_q;
`else
   always_comb acc_nxt = acc_base + ACC_WIDTH'(tree_sum);
   assign out_ovf = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (!stall) begin
         if (tree_vld) acc_q <= acc_nxt;
         out_valid <= tree_vld && tree_last;
         if (tree_vld && tree_last) out_data <= acc_nxt;
      end
   end
endmodule
